// File: rtl/lsq_scheduler.sv
// In-order load/store queue scheduler with a single outstanding data-memory access.
// Define LSQ_MISALIGN_CHECK_EN to trap misaligned halfword/word accesses instead of issuing them.
module lsq_scheduler #(
  parameter int unsigned C_XLEN   = 32,
  parameter int unsigned C_QDEPTH = 4
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  input  logic              ex_lq_wr_i,
  input  logic              ex_sq_wr_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [4:0]        ex_regd_addr_i,
  input  logic [C_XLEN-1:0] ex_regs2_data_i,
  input  logic [C_XLEN-1:0] ex_addr_i,
  output logic              lq_full_o,
  output logic              sq_full_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [C_XLEN-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [C_XLEN-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [C_XLEN-1:0] dmem_rdata_i,
  output logic              wb_regd_wr_o,
  output logic [4:0]        wb_regd_addr_o,
  output logic [C_XLEN-1:0] wb_regd_data_o,
  output logic              misalign_o,
  output logic [C_XLEN-1:0] misalign_addr_o
);
  localparam int unsigned Aw = $clog2(C_QDEPTH);
  localparam logic [1:0] StIdle = 2'd0, StIssue = 2'd1, StWb = 2'd2;

  logic [2:0]        lq_f3_q   [C_QDEPTH];
  logic [4:0]        lq_rd_q   [C_QDEPTH];
  logic [C_XLEN-1:0] lq_addr_q [C_QDEPTH];
  logic [3:0]        lq_tag_q  [C_QDEPTH];
  logic [2:0]        sq_f3_q   [C_QDEPTH];
  logic [C_XLEN-1:0] sq_data_q [C_QDEPTH];
  logic [C_XLEN-1:0] sq_addr_q [C_QDEPTH];
  logic [3:0]        sq_tag_q  [C_QDEPTH];

  logic [Aw-1:0]     lq_wp_q, lq_rp_q, sq_wp_q, sq_rp_q;
  logic [Aw:0]       lq_cnt_q, sq_cnt_q;
  logic [3:0]        seq_q;
  logic [1:0]        state_q, state_d;
  logic              sel_st_q, dmem_we_q;
  logic [2:0]        f3_q;
  logic [1:0]        alo_q;
  logic [4:0]        wb_rd_q;
  logic [3:0]        be_q;
  logic [C_XLEN-1:0] dmem_addr_q, dmem_wdata_q, wb_data_q;

  logic              lq_empty, sq_empty, ld_older, pick_st, sel_mis;
  logic              idle_go, issue, mis_pop, ack;
  logic              lq_pop, sq_pop, lq_push, sq_push;
  logic [3:0]        tag_diff, sel_be;
  logic [2:0]        sel_f3;
  logic [C_XLEN-1:0] sel_addr, ld_ext;
  logic [31:0]       sel_wd, sd, rword, rbyte_sh, rhalf_sh;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;

  assign lq_empty  = (lq_cnt_q == '0);
  assign sq_empty  = (sq_cnt_q == '0);
  assign lq_full_o = (lq_cnt_q == (Aw+1)'(C_QDEPTH));
  assign sq_full_o = (sq_cnt_q == (Aw+1)'(C_QDEPTH));

  // Wrap-aware age: the load head is older iff (store_tag - load_tag) mod 16 is in 1..7.
  assign tag_diff = sq_tag_q[sq_rp_q] - lq_tag_q[lq_rp_q];
  assign ld_older = (tag_diff != 4'd0) && !tag_diff[3];
  assign pick_st  = sq_empty ? 1'b0 : (lq_empty || !ld_older);
  assign sel_f3   = pick_st ? sq_f3_q[sq_rp_q] : lq_f3_q[lq_rp_q];
  assign sel_addr = pick_st ? sq_addr_q[sq_rp_q] : lq_addr_q[lq_rp_q];
  assign sd       = sq_data_q[sq_rp_q][31:0];

`ifdef LSQ_MISALIGN_CHECK_EN
  logic              mis_q;
  logic [C_XLEN-1:0] mis_addr_q;

  assign sel_mis = ((sel_f3[1:0] == 2'b01) && sel_addr[0]) ||
                   ((sel_f3[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00));

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else if (clk_en_i) begin
      mis_q <= mis_pop;
      if (mis_pop) mis_addr_q <= sel_addr;
    end
  end

  assign misalign_o      = mis_q;
  assign misalign_addr_o = mis_addr_q;
`else
  assign sel_mis         = 1'b0;
  assign misalign_o      = 1'b0;
  assign misalign_addr_o = '0;
`endif

  assign idle_go = (state_q == StIdle) && (!lq_empty || !sq_empty);
  assign issue   = idle_go && !sel_mis;
  assign mis_pop = idle_go && sel_mis;
  assign ack     = (state_q == StIssue) && dmem_ack_i;
  assign lq_pop  = (ack && !sel_st_q) || (mis_pop && !pick_st);
  assign sq_pop  = (ack && sel_st_q) || (mis_pop && pick_st);
  // A store wins when both enqueue strobes are high; a full queue still accepts during a pop.
  assign sq_push = ex_sq_wr_i && (!sq_full_o || sq_pop);
  assign lq_push = ex_lq_wr_i && !ex_sq_wr_i && (!lq_full_o || lq_pop);

  // Byte-enable bit i covers byte address i; lanes shifted past bit 3 are dropped.
  always_comb begin
    sel_be = 4'b1111;
    sel_wd = sd;
    case (sel_f3[1:0])
      2'b00: begin
        sel_be = 4'b0001 << sel_addr[1:0];
        sel_wd = {4{sd[7:0]}};
      end
      2'b01: begin
        sel_be = 4'b0011 << sel_addr[1:0];
        sel_wd = {2{sd[15:0]}};
      end
      default: ;
    endcase
  end

  // Read data places byte address 0 in the most significant lane.
  always_comb begin
    rword    = dmem_rdata_i[31:0];
    rbyte_sh = rword << {alo_q, 3'b000};
    rhalf_sh = rword << {alo_q[1], 4'b0000};
    rbyte    = rbyte_sh[31:24];
    rhalf    = rhalf_sh[31:16];
    case (f3_q)
      3'b000:  ld_ext = {{(C_XLEN-8){rbyte[7]}}, rbyte};
      3'b001:  ld_ext = {{(C_XLEN-16){rhalf[15]}}, rhalf};
      3'b100:  ld_ext = {{(C_XLEN-8){1'b0}}, rbyte};
      3'b101:  ld_ext = {{(C_XLEN-16){1'b0}}, rhalf};
      default: ld_ext = C_XLEN'(rword);
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (issue) state_d = StIssue;
      StIssue: if (dmem_ack_i) state_d = sel_st_q ? StIdle : StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clk_en_i && lq_push) begin
      lq_f3_q[lq_wp_q]   <= ex_funct3_i;
      lq_rd_q[lq_wp_q]   <= ex_regd_addr_i;
      lq_addr_q[lq_wp_q] <= ex_addr_i;
      lq_tag_q[lq_wp_q]  <= seq_q;
    end
    if (clk_en_i && sq_push) begin
      sq_f3_q[sq_wp_q]   <= ex_funct3_i;
      sq_data_q[sq_wp_q] <= ex_regs2_data_i;
      sq_addr_q[sq_wp_q] <= ex_addr_i;
      sq_tag_q[sq_wp_q]  <= seq_q;
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q      <= StIdle;
      lq_wp_q      <= '0;
      lq_rp_q      <= '0;
      sq_wp_q      <= '0;
      sq_rp_q      <= '0;
      lq_cnt_q     <= '0;
      sq_cnt_q     <= '0;
      seq_q        <= '0;
      sel_st_q     <= 1'b0;
      dmem_we_q    <= 1'b0;
      f3_q         <= '0;
      alo_q        <= '0;
      wb_rd_q      <= '0;
      be_q         <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      wb_data_q    <= '0;
    end else if (clk_en_i) begin
      state_q  <= state_d;
      if (lq_push) lq_wp_q <= lq_wp_q + Aw'(1);
      if (lq_pop)  lq_rp_q <= lq_rp_q + Aw'(1);
      if (sq_push) sq_wp_q <= sq_wp_q + Aw'(1);
      if (sq_pop)  sq_rp_q <= sq_rp_q + Aw'(1);
      lq_cnt_q <= lq_cnt_q + (Aw+1)'(lq_push) - (Aw+1)'(lq_pop);
      sq_cnt_q <= sq_cnt_q + (Aw+1)'(sq_push) - (Aw+1)'(sq_pop);
      if (lq_push || sq_push) seq_q <= seq_q + 4'd1;
      if (issue) begin
        sel_st_q     <= pick_st;
        dmem_we_q    <= pick_st;
        f3_q         <= sel_f3;
        alo_q        <= sel_addr[1:0];
        be_q         <= sel_be;
        dmem_addr_q  <= {sel_addr[C_XLEN-1:2], 2'b00};
        dmem_wdata_q <= pick_st ? C_XLEN'(sel_wd) : '0;
        if (!pick_st) wb_rd_q <= lq_rd_q[lq_rp_q];
      end
      if (ack && !sel_st_q) wb_data_q <= ld_ext;
    end
  end

  assign dmem_req_o     = (state_q == StIssue);
  assign dmem_we_o      = dmem_we_q;
  assign dmem_addr_o    = dmem_addr_q;
  assign dmem_be_o      = be_q;
  assign dmem_wdata_o   = dmem_wdata_q;
  assign wb_regd_wr_o   = (state_q == StWb) && (wb_rd_q != 5'd0);
  assign wb_regd_addr_o = wb_rd_q;
  assign wb_regd_data_o = wb_data_q;

endmodule

// File: tb/tb_lsq_scheduler.sv
// Self-checking bench for lsq_scheduler: expected memory requests are queued when enqueued
// and compared when the scheduler issues them.
module tb_lsq_scheduler;
  logic        clk, resetb, clk_en;
  logic        lq_wr, sq_wr;
  logic [2:0]  funct3;
  logic [4:0]  regd;
  logic [31:0] sdata, addr;
  logic        lq_full, sq_full;
  logic        req, we;
  logic [31:0] maddr, wdata, rdata;
  logic [3:0]  be;
  logic        ack;
  logic        wb_wr;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mis;
  logic [31:0] mis_addr;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic [31:0] exp;
    int          dly;
  } ld_case_t;

  req_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  lsq_scheduler #(.C_XLEN(32), .C_QDEPTH(4)) dut (
    .clk_i           (clk),
    .resetb_i        (resetb),
    .clk_en_i        (clk_en),
    .ex_lq_wr_i      (lq_wr),
    .ex_sq_wr_i      (sq_wr),
    .ex_funct3_i     (funct3),
    .ex_regd_addr_i  (regd),
    .ex_regs2_data_i (sdata),
    .ex_addr_i       (addr),
    .lq_full_o       (lq_full),
    .sq_full_o       (sq_full),
    .dmem_req_o      (req),
    .dmem_we_o       (we),
    .dmem_addr_o     (maddr),
    .dmem_be_o       (be),
    .dmem_wdata_o    (wdata),
    .dmem_ack_i      (ack),
    .dmem_rdata_i    (rdata),
    .wb_regd_wr_o    (wb_wr),
    .wb_regd_addr_o  (wb_addr),
    .wb_regd_data_o  (wb_data),
    .misalign_o      (mis),
    .misalign_addr_o (mis_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic req_t exp_st(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] d);
    req_t r;
    r.we   = 1'b1;
    r.addr = {a[31:2], 2'b00};
    case (f3[1:0])
      2'b00:   begin r.be = 4'b0001 << a[1:0]; r.wdata = {4{d[7:0]}}; end
      2'b01:   begin r.be = 4'b0011 << a[1:0]; r.wdata = {2{d[15:0]}}; end
      default: begin r.be = 4'b1111; r.wdata = d; end
    endcase
    return r;
  endfunction

  function automatic req_t exp_ld(input logic [31:0] a);
    req_t r;
    r.we    = 1'b0;
    r.addr  = {a[31:2], 2'b00};
    r.be    = '0;
    r.wdata = '0;
    return r;
  endfunction

  task automatic enq_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input bit push);
    sq_wr = 1'b1; funct3 = f3; addr = a; sdata = d;
    if (push) sb.push_back(exp_st(f3, a, d));
    @(negedge clk);
    sq_wr = 1'b0;
  endtask

  task automatic enq_ld(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                        input bit push);
    lq_wr = 1'b1; funct3 = f3; addr = a; regd = rd;
    if (push) sb.push_back(exp_ld(a));
    @(negedge clk);
    lq_wr = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (req === 1'b1);
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    ack    = 1'b0;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetb = 1'b0;
    #1;
    n_checks++;
    if ({req, we, wb_wr, mis} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {req, we, wb_wr, mis});
    end
    n_checks++;
    if ({maddr, be, wdata, wb_addr, wb_data, mis_addr} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h %h %h %h required all 0",
                         maddr, be, wdata, wb_addr, wb_data, mis_addr);
    end
    n_checks++;
    if ({lq_full, sq_full} !== 2'b00) begin
      n_fail++; $display("FAIL reset_full: got %b required 00", {lq_full, sq_full});
    end
    do_reset();
  endtask

  task automatic test_sw();
    req_t e, g;
    enq_st(3'b010, 32'h104, 32'hDEADBEEF, 1'b1);
    n_checks++;
    if (req !== 1'b0) begin n_fail++; $display("FAIL sw_early: got %b required 0", req); end
    @(negedge clk);
    n_checks++;
    if (req !== 1'b1) begin n_fail++; $display("FAIL sw_latency: got %b required 1", req); end
    g = {we, maddr, be, wdata};
    e = sb.pop_front();
    n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL sw_fields: got %h required %h", g, e); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n_checks++;
    if (req !== 1'b0) begin n_fail++; $display("FAIL sw_one_cycle: got %b required 0", req); end
  endtask

  task automatic test_store_lanes();
    req_t e, g;
    bit   ok;
    enq_st(3'b000, 32'h203, 32'h0000005A, 1'b1);
    enq_st(3'b001, 32'h302, 32'h1234BEEF, 1'b1);
    for (int i = 0; i < 2; i++) begin
      wait_req(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL lanes_timeout: got no req required req"); end
      g = {we, maddr, be, wdata};
      e = sb.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL lanes_%0d: got %h required %h", i, g, e); end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
    end
  endtask

  task automatic test_loads();
    ld_case_t cs[7];
    req_t     e;
    bit       ok;
    cs[0] = '{3'b000, 32'h301, 5'd5,  32'h0080_0000, 32'hFFFF_FF80, 3};
    cs[1] = '{3'b100, 32'h301, 5'd5,  32'h0080_0000, 32'h0000_0080, 3};
    cs[2] = '{3'b001, 32'h302, 5'd7,  32'h1234_8001, 32'hFFFF_8001, 0};
    cs[3] = '{3'b101, 32'h300, 5'd8,  32'h8001_7FFF, 32'h0000_8001, 1};
    cs[4] = '{3'b010, 32'h304, 5'd9,  32'hCAFE_F00D, 32'hCAFE_F00D, 2};
    cs[5] = '{3'b000, 32'h300, 5'd10, 32'h7F00_0000, 32'h0000_007F, 0};
    cs[6] = '{3'b010, 32'h400, 5'd0,  32'h1111_1111, 32'h0000_0000, 1};
    for (int i = 0; i < 7; i++) begin
      enq_ld(cs[i].f3, cs[i].a, cs[i].rd, 1'b1);
      wait_req(ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok || {we, maddr} !== {e.we, e.addr}) begin
        n_fail++; $display("FAIL ld_req_%0d: got %b %h required %b %h", i, we, maddr, e.we, e.addr);
      end
      repeat (cs[i].dly) @(negedge clk);
      n_checks++;
      if ({req, maddr} !== {1'b1, e.addr}) begin
        n_fail++; $display("FAIL ld_hold_%0d: got %b %h required 1 %h", i, req, maddr, e.addr);
      end
      rdata = cs[i].rd_data;
      ack   = 1'b1;
      @(negedge clk);
      ack   = 1'b0;
      n_checks++;
      if (cs[i].rd != 5'd0) begin
        if ({wb_wr, wb_addr, wb_data} !== {1'b1, cs[i].rd, cs[i].exp}) begin
          n_fail++; $display("FAIL ld_wb_%0d: got %b %0d %h required 1 %0d %h", i, wb_wr,
                             wb_addr, wb_data, cs[i].rd, cs[i].exp);
        end
      end else if (wb_wr !== 1'b0) begin
        n_fail++; $display("FAIL ld_x0_%0d: got wr %b required 0", i, wb_wr);
      end
      @(negedge clk);
      n_checks++;
      if (wb_wr !== 1'b0) begin
        n_fail++; $display("FAIL ld_pulse_%0d: got %b required 0", i, wb_wr);
      end
    end
  endtask

  task automatic test_order_wrap();
    req_t e, g;
    bit   ok;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      enq_st(3'b010, 32'h1000 + 32'(i * 4), 32'(i), 1'b1);
      wait_req(ok);
      g = {we, maddr, be, wdata};
      e = sb.pop_front();
      n_checks++;
      if (!ok || g !== e) begin n_fail++; $display("FAIL fill_%0d: got %h required %h", i, g, e); end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
    end
    // Tags 14, 15, 0 across the counter wrap.
    enq_ld(3'b010, 32'h2000, 5'd3, 1'b1);
    enq_st(3'b010, 32'h2004, 32'h55, 1'b1);
    enq_ld(3'b010, 32'h2008, 5'd4, 1'b1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wait_req(ok);
      g = {we, maddr, be, wdata};
      e = sb.pop_front();
      n_checks++;
      if (!ok || {g.we, g.addr} !== {e.we, e.addr} || (e.we && g !== e)) begin
        n_fail++; $display("FAIL order_%0d: got %h required %h", i, g, e);
      end
      rdata = 32'h0;
      ack   = 1'b1;
      @(negedge clk);
      ack   = 1'b0;
    end
  endtask

  task automatic test_full();
    req_t e, g;
    bit   ok;
    int   seen = 0;
    int   extra = 0;
    do_reset();
    for (int i = 0; i < 4; i++) enq_st(3'b010, 32'h3000 + 32'(i * 4), 32'hA0 + 32'(i), 1'b1);
    n_checks++;
    if ({sq_full, lq_full} !== 2'b10) begin
      n_fail++; $display("FAIL full_flags: got %b required 10", {sq_full, lq_full});
    end
    enq_st(3'b010, 32'h3FF0, 32'hBAD, 1'b0);
    n_checks++;
    if (sq_full !== 1'b1) begin n_fail++; $display("FAIL full_hold: got %b required 1", sq_full); end
    while (sb.size() > 0) begin
      wait_req(ok);
      g = {we, maddr, be, wdata};
      e = sb.pop_front();
      n_checks++;
      if (!ok || g !== e) begin n_fail++; $display("FAIL full_st_%0d: got %h required %h", seen, g, e); end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      seen++;
    end
    for (int i = 0; i < 10; i++) begin
      if (req === 1'b1) extra++;
      @(negedge clk);
    end
    n_checks++;
    if (seen + extra !== 4) begin
      n_fail++; $display("FAIL full_count: got %0d stores required 4", seen + extra);
    end
    // A full queue must accept an enqueue that coincides with its own pop.
    for (int i = 0; i < 4; i++) enq_st(3'b010, 32'h4000 + 32'(i * 4), 32'hB0 + 32'(i), 1'b1);
    seen = 0;
    while (sb.size() > 0 && seen < 8) begin
      wait_req(ok);
      g = {we, maddr, be, wdata};
      e = sb.pop_front();
      n_checks++;
      if (!ok || g !== e) begin n_fail++; $display("FAIL fullpop_%0d: got %h required %h", seen, g, e); end
      ack = 1'b1;
      if (seen == 0) enq_st(3'b010, 32'h4100, 32'hC5, 1'b1);
      else @(negedge clk);
      ack = 1'b0;
      seen++;
    end
    n_checks++;
    if (seen !== 5) begin n_fail++; $display("FAIL fullpop_count: got %0d required 5", seen); end
  endtask

  task automatic test_misalign();
    int   reqs = 0;
    int   pulses = 0;
    logic [31:0] cap = '0;
`ifdef LSQ_MISALIGN_CHECK_EN
    enq_ld(3'b001, 32'h101, 5'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (req === 1'b1) reqs++;
      if (mis === 1'b1) begin pulses++; cap = mis_addr; end
      @(negedge clk);
    end
    n_checks++;
    if (reqs !== 0) begin n_fail++; $display("FAIL mis_noreq: got %0d req cycles required 0", reqs); end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL mis_pulse: got %0d pulses required 1", pulses); end
    n_checks++;
    if (cap !== 32'h101) begin n_fail++; $display("FAIL mis_addr: got %h required 00000101", cap); end
`else
    req_t e, g;
    bit   ok;
    enq_ld(3'b001, 32'h101, 5'd3, 1'b1);
    enq_st(3'b001, 32'h103, 32'h0000BEEF, 1'b1);
    for (int i = 0; i < 2; i++) begin
      wait_req(ok);
      g = {we, maddr, be, wdata};
      e = sb.pop_front();
      n_checks++;
      if (!ok || {g.we, g.addr} !== {e.we, e.addr} || (e.we && g !== e)) begin
        n_fail++; $display("FAIL noMis_%0d: got %h required %h", i, g, e);
      end
      if (mis === 1'b1) pulses++;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      if (mis === 1'b1) pulses++;
      @(negedge clk);
    end
    n_checks++;
    if (pulses !== 0 || mis_addr !== 32'h0) begin
      n_fail++; $display("FAIL noMis_tie: got %0d pulses addr %h required 0", pulses, mis_addr);
    end
    reqs = 0;
    cap  = 0;
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    int reqs = 0;
    enq_st(3'b010, 32'h500, 32'h11, 1'b1);
    wait_req(ok);
    #2 resetb = 1'b0;
    #1;
    n_checks++;
    if (!ok || {req, we, maddr, be, wdata} !== '0) begin
      n_fail++; $display("FAIL rst_mid: got req %b we %b addr %h required all 0", req, we, maddr);
    end
    sb.delete();
    @(negedge clk);
    resetb = 1'b1;
    ack    = 1'b1;
    @(negedge clk);
    ack    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (req === 1'b1) reqs++;
      @(negedge clk);
    end
    n_checks++;
    if (reqs !== 0 || sq_full !== 1'b0) begin
      n_fail++; $display("FAIL rst_late_ack: got %0d req cycles required 0", reqs);
    end
  endtask

  task automatic test_clk_en();
    req_t e, g;
    bit   ok;
    int   reqs = 0;
    clk_en = 1'b0;
    enq_st(3'b010, 32'h600, 32'h1, 1'b0);
    clk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (req === 1'b1) reqs++;
      @(negedge clk);
    end
    n_checks++;
    if (reqs !== 0) begin n_fail++; $display("FAIL clken_enq: got %0d req cycles required 0", reqs); end
    enq_st(3'b010, 32'h604, 32'h2, 1'b1);
    wait_req(ok);
    g = {we, maddr, be, wdata};
    e = sb.pop_front();
    n_checks++;
    if (!ok || g !== e) begin n_fail++; $display("FAIL clken_req: got %h required %h", g, e); end
    clk_en = 1'b0;
    ack    = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req !== 1'b1) begin n_fail++; $display("FAIL clken_hold: got %b required 1", req); end
    clk_en = 1'b1;
    @(negedge clk);
    ack    = 1'b0;
    n_checks++;
    if (req !== 1'b0) begin n_fail++; $display("FAIL clken_ack: got %b required 0", req); end
  endtask

  initial begin
    resetb = 1'b1; clk_en = 1'b1; lq_wr = 1'b0; sq_wr = 1'b0; funct3 = '0;
    regd = '0; sdata = '0; addr = '0; ack = 1'b0; rdata = '0;
    test_reset();
    test_sw();
    test_store_lanes();
    test_loads();
    test_order_wrap();
    test_full();
    test_misalign();
    test_reset_mid();
    test_clk_en();
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++; $display("FAIL sb_drained: got %0d pending required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
